// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared types, CSR addresses and mstatus update helpers for
//               the CSR access sequencer.
// Revision    : 1.0
// ============================================================================
package csr_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_TRAP  = 3'd3,
        OP_MRET  = 3'd4
    } csr_op_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD    = 4'd1,
        S_WR    = 4'd2,
        S_T_EPC = 4'd3,
        S_T_SRD = 4'd4,
        S_T_SWR = 4'd5,
        S_M_SRD = 4'd6,
        S_M_SWR = 4'd7,
        S_M_ERD = 4'd8,
        S_DONE  = 4'd9
    } ctrl_state_t;

    localparam logic [11:0] MSTATUS_ADDR     = 12'h300;
    localparam logic [11:0] MEPC_ADDR        = 12'h341;
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r                   = s;
        r[MSTATUS_MPIE_BIT] = s[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r                   = s;
        r[MSTATUS_MIE_BIT]  = s[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_alu.sv
`default_nettype none
// ============================================================================
// Module      : csr_alu
// Description : New CSR value and write-enable for CSRRW/CSRRS/CSRRC.
// Revision    : 1.0
// ============================================================================
module csr_alu
    import csr_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    output logic [31:0] new_val,
    output logic        wr_en
);

    // Set/clear with a zero operand must not write (side-effect free read).
    always_comb begin
        new_val = 32'h0;
        wr_en   = 1'b0;
        case (op)
            OP_CSRRW: begin
                new_val = operand;
                wr_en   = 1'b1;
            end
            OP_CSRRS: begin
                new_val = old_val | operand;
                wr_en   = (operand != 32'h0);
            end
            OP_CSRRC: begin
                new_val = old_val & ~operand;
                wr_en   = (operand != 32'h0);
            end
            default: begin
                new_val = 32'h0;
                wr_en   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl
// Description : Expands CSR ops, trap entry and MRET into CSR file strobes.
// Revision    : 1.0
// ============================================================================
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        csr_rd,
    output logic        csr_wr,
    input  logic [31:0] rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    ctrl_state_t state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] csr_q, csr_d;
    logic [31:0] opnd_q, opnd_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] old_q, old_d;
    logic [31:0] tmp_q, tmp_d;

    logic [31:0] alu_new;
    logic        alu_we;
    logic        pc_lo_unused;

    // The faulting PC is word-aligned before being stored in mepc.
    assign pc_lo_unused = ^req_pc[1:0];

    csr_alu u_alu (
        .op      (op_q),
        .old_val (old_q),
        .operand (opnd_q),
        .new_val (alu_new),
        .wr_en   (alu_we)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            csr_q   <= 12'h0;
            opnd_q  <= 32'h0;
            pc_q    <= 30'h0;
            old_q   <= 32'h0;
            tmp_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            csr_q   <= csr_d;
            opnd_q  <= opnd_d;
            pc_q    <= pc_d;
            old_q   <= old_d;
            tmp_q   <= tmp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        csr_d   = csr_q;
        opnd_d  = opnd_q;
        pc_d    = pc_q;
        old_d   = old_q;
        tmp_d   = tmp_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    csr_d  = req_csr;
                    opnd_d = req_wdata;
                    pc_d   = req_pc[31:2];
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_RD;
                        OP_TRAP:                      state_d = S_T_EPC;
                        OP_MRET:                      state_d = S_M_SRD;
                        default:                      state_d = S_DONE;
                    endcase
                end
            end
            S_RD: begin
                old_d   = rdata;
                state_d = alu_we ? S_WR : S_DONE;
            end
            S_WR:    state_d = S_DONE;
            S_T_EPC: state_d = S_T_SRD;
            S_T_SRD: begin
                tmp_d   = rdata;
                state_d = S_T_SWR;
            end
            S_T_SWR: state_d = S_DONE;
            S_M_SRD: begin
                tmp_d   = rdata;
                state_d = S_M_SWR;
            end
            S_M_SWR: state_d = S_M_ERD;
            S_M_ERD: begin
                tmp_d   = rdata;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        addr           = 32'h0;
        wdata          = 32'h0;
        csr_rd         = 1'b0;
        csr_wr         = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_RD: begin
                csr_rd = 1'b1;
                addr   = {20'h0, csr_q};
            end
            S_WR: begin
                csr_wr = 1'b1;
                addr   = {20'h0, csr_q};
                wdata  = alu_new;
            end
            S_T_EPC: begin
                csr_wr = 1'b1;
                addr   = {20'h0, MEPC_ADDR};
                wdata  = {pc_q, 2'b00};
            end
            S_T_SRD, S_M_SRD: begin
                csr_rd = 1'b1;
                addr   = {20'h0, MSTATUS_ADDR};
            end
            S_T_SWR: begin
                csr_wr = 1'b1;
                addr   = {20'h0, MSTATUS_ADDR};
                wdata  = mstatus_on_trap(tmp_q);
            end
            S_M_SWR: begin
                csr_wr = 1'b1;
                addr   = {20'h0, MSTATUS_ADDR};
                wdata  = mstatus_on_mret(tmp_q);
            end
            S_M_ERD: begin
                csr_rd = 1'b1;
                addr   = {20'h0, MEPC_ADDR};
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = is_csr_op(op_q) ? old_q : 32'h0;
                if (op_q == OP_TRAP) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = MTVEC;
                end else if (op_q == OP_MRET) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = tmp_q;
                end
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Self-checking bench with a transaction-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_csr_access_ctrl;
    import csr_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic [31:0] rr;
        logic        dv;
        logic [31:0] dpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [11:0] req_csr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;
    logic [31:0] addr, wdata, rdata, resp_rdata, redirect_pc;
    logic        csr_rd, csr_wr, resp_valid, redirect_valid;

    logic [31:0] csr_file [4096];
    logic [31:0] ref_mem  [4096];
    exp_t        exp_q[$];
    logic        cur_busy;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    csr_access_ctrl #(.MTVEC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_csr        (req_csr),
        .req_wdata      (req_wdata),
        .req_pc         (req_pc),
        .addr           (addr),
        .wdata          (wdata),
        .csr_rd         (csr_rd),
        .csr_wr         (csr_wr),
        .rdata          (rdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // CSR file: combinational read, write taken mid-cycle while the strobe is stable.
    assign rdata = csr_rd ? csr_file[addr[11:0]] : 32'h0;
    initial begin
        for (int i = 0; i < 4096; i++) csr_file[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (csr_wr) csr_file[addr[11:0]] = wdata;
        end
    end

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic rd, input logic wr, input logic [11:0] a,
                                input logic [31:0] wd);
        exp_t e;
        e.rd = rd; e.wr = wr; e.addr = {20'h0, a}; e.wdata = wd;
        e.rv = 1'b0; e.rr = 32'h0; e.dv = 1'b0; e.dpc = 32'h0;
        return e;
    endfunction

    function automatic exp_t mk_done(input logic [31:0] rr, input logic dv, input logic [31:0] dpc);
        exp_t e;
        e = mk(1'b0, 1'b0, 12'h0, 32'h0);
        e.rv = 1'b1; e.rr = rr; e.dv = dv; e.dpc = dpc;
        return e;
    endfunction

    // Reference model: whole request expanded into its per-cycle bus activity.
    task automatic build(input logic [2:0] op, input logic [11:0] csr,
                         input logic [31:0] wd, input logic [31:0] pc);
        logic [31:0] old, nv, s;
        logic        do_wr;
        old = ref_mem[csr];
        if (op == OP_CSRRW || op == OP_CSRRS || op == OP_CSRRC) begin
            if (op == OP_CSRRW)      begin nv = wd;         do_wr = 1'b1;        end
            else if (op == OP_CSRRS) begin nv = old | wd;   do_wr = (wd != 0);  end
            else                     begin nv = old & ~wd;  do_wr = (wd != 0);  end
            exp_q.push_back(mk(1'b1, 1'b0, csr, 32'h0));
            if (do_wr) exp_q.push_back(mk(1'b0, 1'b1, csr, nv));
            exp_q.push_back(mk_done(old, 1'b0, 32'h0));
        end else if (op == OP_TRAP) begin
            s = ref_mem[12'h300];
            nv = (s & ~32'h88) | (s[3] ? 32'h80 : 32'h0);
            exp_q.push_back(mk(1'b0, 1'b1, 12'h341, pc & 32'hFFFF_FFFC));
            exp_q.push_back(mk(1'b1, 1'b0, 12'h300, 32'h0));
            exp_q.push_back(mk(1'b0, 1'b1, 12'h300, nv));
            exp_q.push_back(mk_done(32'h0, 1'b1, 32'h100));
        end else if (op == OP_MRET) begin
            s = ref_mem[12'h300];
            nv = (s & ~32'h88) | 32'h80 | (s[7] ? 32'h08 : 32'h0);
            exp_q.push_back(mk(1'b1, 1'b0, 12'h300, 32'h0));
            exp_q.push_back(mk(1'b0, 1'b1, 12'h300, nv));
            exp_q.push_back(mk(1'b1, 1'b0, 12'h341, 32'h0));
            exp_q.push_back(mk_done(32'h0, 1'b1, ref_mem[12'h341]));
        end else begin
            exp_q.push_back(mk_done(32'h0, 1'b0, 32'h0));
        end
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
        cur_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n && !cur_busy && req_valid) build(req_op, req_csr, req_wdata, req_pc);
            #1;
            if (!rst_n) exp_q.delete();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_busy = 1'b1;
                if (e.wr) ref_mem[e.addr[11:0]] = e.wdata;
                chk("cycle", {req_ready, csr_rd, csr_wr, addr, wdata, resp_valid, resp_rdata,
                              redirect_valid, redirect_pc},
                    {1'b0, e.rd, e.wr, e.addr, e.wdata, e.rv, e.rr, e.dv, e.dpc});
            end else begin
                cur_busy = 1'b0;
                chk("idle", {req_ready, csr_rd, csr_wr, addr, wdata, resp_valid, resp_rdata,
                             redirect_valid, redirect_pc},
                    {1'b1, 132'h0});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] wd,
                         input logic [31:0] pc, input int lat, input logic [31:0] exp_rd,
                         input logic exp_dv, input logic [31:0] exp_pc);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_csr = csr; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_valid = 1'b0; req_op = OP_CSRRC; req_csr = 12'hFFF;
                req_wdata = 32'hFFFF_FFFF; req_pc = 32'hFFFF_FFFF;
            end
        end while (!resp_valid && k < 10);
        chk("latency", 133'(k), 133'(lat));
        chk("resp_rdata", {101'h0, resp_rdata}, {101'h0, exp_rd});
        chk("redirect_valid", {132'h0, redirect_valid}, {132'h0, exp_dv});
        chk("redirect_pc", {101'h0, redirect_pc}, {101'h0, exp_pc});
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {req_ready, csr_rd, csr_wr, addr, wdata, resp_valid, resp_rdata,
                              redirect_valid, redirect_pc}, {1'b1, 132'h0});
        rst_n = 1'b1;

        issue(OP_CSRRW, 12'h341, 32'hDEAD_BEEF, 32'h0, 3, 32'h0, 1'b0, 32'h0);
        chk("mepc_after_rw", {101'h0, csr_file[12'h341]}, {101'h0, 32'hDEAD_BEEF});
        issue(OP_CSRRS, 12'h341, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 32'h0);
        issue(OP_CSRRW, 12'h300, 32'h08, 32'h0, 3, 32'h0, 1'b0, 32'h0);
        issue(OP_CSRRC, 12'h300, 32'h08, 32'h0, 3, 32'h08, 1'b0, 32'h0);
        chk("mstatus_after_rc", {101'h0, csr_file[12'h300]}, {101'h0, 32'h0});
        issue(OP_CSRRS, 12'h300, 32'h80, 32'h0, 3, 32'h0, 1'b0, 32'h0);
        chk("mstatus_after_rs", {101'h0, csr_file[12'h300]}, {101'h0, 32'h80});
        issue(OP_CSRRW, 12'h300, 32'h08, 32'h0, 3, 32'h80, 1'b0, 32'h0);

        issue(OP_TRAP, 12'h0, 32'h0, 32'h0000_1236, 4, 32'h0, 1'b1, 32'h100);
        chk("trap_mepc", {101'h0, csr_file[12'h341]}, {101'h0, 32'h0000_1234});
        chk("trap_mstatus", {101'h0, csr_file[12'h300]}, {101'h0, 32'h80});
        issue(OP_MRET, 12'h0, 32'h0, 32'h0, 4, 32'h0, 1'b1, 32'h0000_1234);
        chk("mret_mstatus", {101'h0, csr_file[12'h300]}, {101'h0, 32'h88});

        // req_valid held high: one accept per DONE->IDLE transition.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MRET;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) pulses += int'(resp_valid);
            else        req_valid = 1'b0;
        end
        chk("held_valid_pulses", 133'(pulses), 133'(2));

        issue(3'd7, 12'h123, 32'h5, 32'h0, 1, 32'h0, 1'b0, 32'h0);

        // Reset during T_SRD of a trap.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_TRAP; req_pc = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t_srd_read", {132'h0, csr_rd}, {132'h0, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {req_ready, csr_rd, csr_wr, addr, wdata, resp_valid,
                                    resp_rdata, redirect_valid, redirect_pc}, {1'b1, 132'h0});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mstatus", {101'h0, csr_file[12'h300]}, {101'h0, 32'h88});
        chk("abort_mepc", {101'h0, csr_file[12'h341]}, {101'h0, 32'h0000_2000});
        issue(OP_CSRRW, 12'h340, 32'h55, 32'h0, 3, 32'h0, 1'b0, 32'h0);
        chk("mscratch", {101'h0, csr_file[12'h340]}, {101'h0, 32'h55});

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
